ksa: RTL and testbench



---
 rtl/ksa_if.sv | 20 ++
 rtl/ksa.sv | 108 ++++++++++
 tb/tb_ksa.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/ksa_if.sv
// Start handshake and S-memory port of the ARC4 key-scheduling stage.
interface ksa_if;
    logic        en;
    logic        rdy;
    logic [23:0] key;
    logic [7:0]  addr;
    logic [7:0]  rddata;
    logic [7:0]  wrdata;
    logic        wren;

    modport master (
        output en, key, rddata,
        input  rdy, addr, wrdata, wren
    );

    modport slave (
        input  en, key, rddata,
        output rdy, addr, wrdata, wren
    );
endinterface

// File: rtl/ksa.sv
// ARC4 key schedule: permutes S in place under a latched 24-bit key,
// six cycles per index over a shared single-port synchronous RAM.
module ksa (
    input logic  clk,
    input logic  rst_n,
    ksa_if.slave bus
);
    typedef enum logic [2:0] {
        IDLE, RD_I, WT_I, RD_J, WT_J, WR_I, WR_J
    } state_t;

    state_t      state;
    state_t      state_nx;
    logic [7:0]  i;
    logic [7:0]  j;
    logic [7:0]  si;
    logic [7:0]  sj;
    logic [23:0] key_q;
    logic [1:0]  km;
    logic [7:0]  kb;

    // km tracks i mod 3 so no divider is needed
    always_comb begin
        kb = key_q[7:0];
        unique case (km)
            2'd0:    kb = key_q[23:16];
            2'd1:    kb = key_q[15:8];
            default: kb = key_q[7:0];
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            i     <= '0;
            j     <= '0;
            si    <= '0;
            sj    <= '0;
            key_q <= '0;
            km    <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (bus.en) begin
                        key_q <= bus.key;
                        i     <= '0;
                        j     <= '0;
                        km    <= '0;
                    end
                end
                WT_I: begin
                    si <= bus.rddata;
                    j  <= j + bus.rddata + kb;
                end
                WT_J: sj <= bus.rddata;
                WR_J: begin
                    if (i != 8'hFF) begin
                        i  <= i + 8'd1;
                        km <= (km == 2'd2) ? 2'd0 : km + 2'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (bus.en) state_nx = RD_I;
            RD_I:    state_nx = WT_I;
            WT_I:    state_nx = RD_J;
            RD_J:    state_nx = WT_J;
            WT_J:    state_nx = WR_I;
            WR_I:    state_nx = WR_J;
            WR_J:    state_nx = (i == 8'hFF) ? IDLE : RD_I;
            default: state_nx = IDLE;
        endcase
    end

    // outputs decode state and registers only
    always_comb begin
        bus.rdy    = 1'b0;
        bus.addr   = '0;
        bus.wrdata = '0;
        bus.wren   = 1'b0;
        unique case (state)
            IDLE:       bus.rdy  = 1'b1;
            RD_I, WT_I: bus.addr = i;
            RD_J, WT_J: bus.addr = j;
            WR_I: begin
                bus.addr   = i;
                bus.wrdata = sj;
                bus.wren   = 1'b1;
            end
            WR_J: begin
                bus.addr   = j;
                bus.wrdata = si;
                bus.wren   = 1'b1;
            end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_ksa.sv
// Bench for ksa: RAM model, write monitor and a software ARC4 KSA reference.
module tb_ksa;
    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    ksa_if bus ();

    ksa dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    logic [7:0] mem [256];
    bit         do_init = 1'b0;

    // stands in for the init stage and the synchronous S RAM
    always @(posedge clk) begin
        if (do_init) begin
            for (int k = 0; k < 256; k++) mem[k] <= 8'(k);
        end else if (bus.wren === 1'b1) begin
            mem[bus.addr] <= bus.wrdata;
        end
        bus.rddata <= mem[bus.addr];
    end

    logic [15:0] wq [$];
    always @(negedge clk)
        if (bus.wren === 1'b1) wq.push_back({bus.addr, bus.wrdata});

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wchk(input string tag, input int idx,
                        input logic [7:0] a, input logic [7:0] d);
        logic [15:0] got;
        got = (idx < wq.size()) ? wq[idx] : 16'hxxxx;
        chk(tag, {16'h0, got}, {16'h0, a, d});
    endtask

    logic [7:0]  ms [256];
    logic [15:0] eq [$];

    task automatic model(input logic [23:0] k);
        logic [7:0] jj;
        logic [7:0] kb;
        logic [7:0] t;
        jj = 8'd0;
        eq.delete();
        for (int n = 0; n < 256; n++) ms[n] = 8'(n);
        for (int n = 0; n < 256; n++) begin
            kb = 8'(k >> (8 * (2 - (n % 3))));
            jj = jj + ms[n] + kb;
            eq.push_back({8'(n), ms[jj]});
            eq.push_back({jj, ms[n]});
            t      = ms[n];
            ms[n]  = ms[jj];
            ms[jj] = t;
        end
    endtask

    task automatic verify(input string tag, input logic [23:0] k);
        int bad;
        model(k);
        chk({tag, "_wlen"}, wq.size(), 512);
        bad = 0;
        for (int n = 0; n < 512; n++)
            if (n >= wq.size() || wq[n] !== eq[n]) bad++;
        chk({tag, "_wseq"}, bad, 0);
        bad = 0;
        for (int n = 0; n < 256; n++)
            if (mem[n] !== ms[n]) bad++;
        chk({tag, "_smem"}, bad, 0);
    endtask

    task automatic run(input logic [23:0] k, input string tag,
                       input bit poke, input int abort_at,
                       output int cyc);
        @(negedge clk);
        do_init = 1'b1;
        @(negedge clk);
        do_init = 1'b0;
        wq.delete();
        bus.key = k;
        bus.en  = 1'b1;
        @(posedge clk);
        #1;
        chk({tag, "_rdy_fall"}, bus.rdy, 0);
        chk({tag, "_addr0"}, bus.addr, 0);
        @(negedge clk);
        bus.en = 1'b0;
        cyc = 0;
        while (cyc < 2000) begin
            @(posedge clk);
            cyc++;
            #1;
            if (bus.rdy === 1'b1) break;
            if (poke && cyc == 300) begin
                bus.en  = 1'b1;
                bus.key = ~k;
            end
            if (poke && cyc == 301) bus.en = 1'b0;
            if (cyc == abort_at) begin
                rst_n = 1'b0;
                #1;
                chk({tag, "_abort_rdy"}, bus.rdy, 1);
                chk({tag, "_abort_wren"}, bus.wren, 0);
                chk({tag, "_abort_addr"}, bus.addr, 0);
                break;
            end
        end
    endtask

    initial begin
        int cyc;
        logic [23:0] rk;
        bus.en  = 1'b0;
        bus.key = 24'h0;

        #3 rst_n = 1'b0;
        #1;
        chk("rst_rdy", bus.rdy, 1);
        chk("rst_wren", bus.wren, 0);
        chk("rst_addr", bus.addr, 0);
        chk("rst_wrdata", bus.wrdata, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("idle_rdy", bus.rdy, 1);
        chk("idle_wren", bus.wren, 0);
        chk("idle_addr", bus.addr, 0);

        run(24'h000000, "k0", 1'b0, -1, cyc);
        chk("k0_cycles", cyc, 1536);
        wchk("k0_w0", 0, 8'd0, 8'd0);
        wchk("k0_w1", 1, 8'd0, 8'd0);
        wchk("k0_w2", 2, 8'd1, 8'd1);
        wchk("k0_w3", 3, 8'd1, 8'd1);
        wchk("k0_w4", 4, 8'd2, 8'd3);
        wchk("k0_w5", 5, 8'd3, 8'd2);
        wchk("k0_w6", 6, 8'd3, 8'd5);
        wchk("k0_w7", 7, 8'd5, 8'd2);
        verify("k0", 24'h000000);

        run(24'h010203, "k123", 1'b1, -1, cyc);
        chk("k123_cycles", cyc, 1536);
        wchk("k123_w0", 0, 8'd0, 8'd1);
        wchk("k123_w1", 1, 8'd1, 8'd0);
        wchk("k123_w2", 2, 8'd1, 8'd3);
        wchk("k123_w3", 3, 8'd3, 8'd0);
        wchk("k123_w4", 4, 8'd2, 8'd8);
        wchk("k123_w5", 5, 8'd8, 8'd2);
        verify("k123", 24'h010203);

        run(24'h010203, "again", 1'b0, -1, cyc);
        chk("again_cycles", cyc, 1536);
        wchk("again_w0", 0, 8'd0, 8'd1);
        verify("again", 24'h010203);

        run(24'hFFFFFF, "kff", 1'b0, -1, cyc);
        chk("kff_cycles", cyc, 1536);
        wchk("kff_w0", 0, 8'h00, 8'hFF);
        wchk("kff_w1", 1, 8'hFF, 8'h00);
        wchk("kff_w2", 2, 8'h01, 8'h00);
        wchk("kff_w3", 3, 8'hFF, 8'h01);
        verify("kff", 24'hFFFFFF);

        for (int r = 0; r < 2; r++) begin
            rk = 24'($urandom);
            run(rk, "rnd", 1'b0, -1, cyc);
            chk("rnd_cycles", cyc, 1536);
            verify("rnd", rk);
        end

        rk = 24'($urandom);
        run(rk, "abort", 1'b0, 700, cyc);
        chk("abort_at", cyc, 700);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        run(rk, "rerun", 1'b0, -1, cyc);
        chk("rerun_cycles", cyc, 1536);
        verify("rerun", rk);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule
